// File: rtl/counter_pkg.sv
// Shared constants and helpers for the prescaled wrap-around counter.
package counter_pkg;

  localparam int CNT_W       = 4;
  localparam int DIV_DEFAULT = 1;
  localparam int MAX_DEFAULT = 15;

  // Prescaler register width: ceil(log2(div)), never below one bit.
  function automatic int presc_width(input int div);
    int w;
    w = $clog2(div);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/top_counter_tick_gen.sv
// Prescaler: counts 0..DIV-1 and flags a tick while it sits at DIV-1.
module tick_gen
  import counter_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = presc_width(DIV);

  logic [PW-1:0] pre;

  // Decoded from the register only, so tick is high for exactly the edge that rolls pre over.
  assign tick = (pre == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/top_counter.sv
// Counter that steps once per prescaler tick and wraps from MAX back to 0.
module top_counter
  import counter_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int MAX = MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] po_cnt
);

  if (DIV < 1 || DIV > 65536 || MAX < 1 || MAX > 15) begin : g_bad_param
    $fatal(1, "top_counter: illegal parameters DIV=%0d MAX=%0d", DIV, MAX);
  end

  logic tick;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Reset wins over a tick landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      po_cnt <= '0;
    end else if (tick) begin
      if (po_cnt == CNT_W'(MAX)) begin
        po_cnt <= '0;
      end else begin
        po_cnt <= po_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_top_counter.sv
// Directed bench for top_counter: four parameterisations side by side, each checked against hand values and a reference model.
module tb_top_counter;

  logic       clk;
  logic [3:0] rst;
  logic [3:0] cnt [4];

  int checks;
  int errors;

  // Reference model state per instance: 0 default, 1 DIV=4, 2 MAX=9, 3 DIV=3.
  int m_div [4] = '{1, 4, 1, 3};
  int m_max [4] = '{15, 15, 9, 15};
  int m_pre [4];
  int m_cnt [4];
  bit m_vld [4];

  top_counter u_a (.clk(clk), .rst(rst[0]), .po_cnt(cnt[0]));
  top_counter #(.DIV(4)) u_b (.clk(clk), .rst(rst[1]), .po_cnt(cnt[1]));
  top_counter #(.MAX(9)) u_c (.clk(clk), .rst(rst[2]), .po_cnt(cnt[2]));
  top_counter #(.DIV(3)) u_d (.clk(clk), .rst(rst[3]), .po_cnt(cnt[3]));

  // 20 ns period, rising edges at 10, 30, 50, ...
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      if (rst[i]) begin
        m_pre[i] = 0;
        m_cnt[i] = 0;
        m_vld[i] = 1'b1;
      end else if (m_vld[i]) begin
        if (m_pre[i] == m_div[i] - 1) begin
          m_pre[i] = 0;
          m_cnt[i] = (m_cnt[i] == m_max[i]) ? 0 : m_cnt[i] + 1;
        end else begin
          m_pre[i] = m_pre[i] + 1;
        end
      end
    end
  endtask

  // One rising edge, then compare every initialised instance with the model 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) begin
      if (m_vld[i]) chk($sformatf("model_%0d", i), cnt[i], 4'(m_cnt[i]));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 4'hF;

    // Reset held for the edges at 10..90 ns.
    repeat (5) step();
    chk("rst_a", cnt[0], 4'd0);
    chk("rst_b", cnt[1], 4'd0);
    chk("rst_c", cnt[2], 4'd0);
    chk("rst_d", cnt[3], 4'd0);

    rst = 4'h0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("seq_a_%0d", k), cnt[0], 4'(k % 16));
      chk($sformatf("seq_b_%0d", k), cnt[1], 4'(k / 4));
      chk($sformatf("seq_c_%0d", k), cnt[2], 4'(k % 10));
      chk($sformatf("seq_d_%0d", k), cnt[3], 4'(k / 3));
    end
    chk("a_wrapped", cnt[0], 4'd0);

    // Default instance: reset pulse while the count is 7.
    repeat (7) step();
    chk("a_at7", cnt[0], 4'd7);
    rst[0] = 1'b1;
    step();
    chk("a_pulse_rst", cnt[0], 4'd0);
    rst[0] = 1'b0;
    step();
    chk("a_after_pulse", cnt[0], 4'd1);

    // DIV=3: reset lands while the prescaler holds 2, so the pending tick is dropped.
    rst[3] = 1'b1;
    step();
    rst[3] = 1'b0;
    step();
    step();
    chk("d_pre2", cnt[3], 4'd0);
    rst[3] = 1'b1;
    step();
    chk("d_rst_on_tick", cnt[3], 4'd0);
    rst[3] = 1'b0;
    step();
    chk("d_rel_1", cnt[3], 4'd0);
    step();
    chk("d_rel_2", cnt[3], 4'd0);
    step();
    chk("d_rel_3", cnt[3], 4'd1);

    // Long reset: everything stays at 0 for 50 edges.
    rst = 4'hF;
    for (int k = 0; k < 50; k++) begin
      step();
      chk($sformatf("hold_a_%0d", k), cnt[0], 4'd0);
      chk($sformatf("hold_d_%0d", k), cnt[3], 4'd0);
    end
    rst = 4'h0;
    step();
    chk("post_a", cnt[0], 4'd1);
    chk("post_b", cnt[1], 4'd0);
    chk("post_c", cnt[2], 4'd1);
    chk("post_d", cnt[3], 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
